// File: rtl/awgn_burst_ctrl.sv
// Burst sequencer for the Box-Muller AWGN core: gates the core,
// buffers its sample pairs and streams them out one at a time.
module awgn_burst_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int HEADROOM   = 4,
  parameter int CNT_W      = 16
) (
  input  logic              CLK_100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] core_x0,
  input  logic [DATA_W-1:0] core_x1,
  input  logic              core_valid,
  output logic              core_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] HEAD_C  = (AW+1)'(HEADROOM);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, free;
  logic [CNT_W-1:0]  len, in_cnt, out_cnt, in_cnt_nx;

  logic       in_run, len_open, one_left;
  logic       push_ok, drop, pop, fin;
  logic [1:0] push_n;

  always_comb begin
    free     = DEPTH_C - count;
    in_run   = (state == RUN);
    len_open = (len == '0) || (in_cnt < len);
    one_left = (len != '0) && (len - in_cnt == CNT_W'(1));
    push_ok  = in_run && core_valid && len_open && (free >= TWO_C);
    drop     = in_run && core_valid && len_open && (free < TWO_C);
    push_n   = 2'd0;
    if (push_ok) push_n = one_left ? 2'd1 : 2'd2;
    in_cnt_nx = in_cnt;
    if (push_ok && len != '0)
      in_cnt_nx = one_left ? len : in_cnt + CNT_W'(2);
  end

  always_comb begin
    m_valid = (count != '0);
    m_data  = m_valid ? mem[rd_ptr] : '0;
    m_last  = m_valid && (len != '0) &&
              (out_cnt == len - CNT_W'(1));
    pop     = m_valid && m_ready;
    fin     = pop && m_last && (state != IDLE);
    core_en = in_run && (free >= HEAD_C) && len_open;
    busy    = (state != IDLE);
  end

  // abort beats everything, including a same-cycle start
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (start) state_nx = RUN;
        RUN:
          if (fin)
            state_nx = IDLE;
          else if (len != '0 && in_cnt_nx == len)
            state_nx = DRAIN;
        DRAIN:
          if (fin) state_nx = IDLE;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (push_ok) begin
      mem[wr_ptr] <= core_x0;
      if (push_n == 2'd2)
        mem[wr_ptr + AW'(1)] <= core_x1;
    end
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      len      <= '0;
      in_cnt   <= '0;
      out_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nx;
      done  <= fin && !abort;
      if (abort) begin
        in_cnt  <= '0;
        out_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
      end else begin
        if (state == IDLE && start) begin
          len      <= burst_len;
          in_cnt   <= '0;
          out_cnt  <= '0;
          overflow <= 1'b0;
        end else begin
          in_cnt <= in_cnt_nx;
          if (pop) out_cnt <= out_cnt + CNT_W'(1);
          if (drop) overflow <= 1'b1;
        end
        wr_ptr <= wr_ptr + AW'(push_n);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + (AW+1)'(push_n) - (AW+1)'(pop);
      end
    end
  end

endmodule
